// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared constants, FSM state type and checksum helper for the vote reporter
package vote_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] c1, input logic [7:0] c2,
                                                input logic [7:0] c3, input logic [7:0] c4);
    return c1 ^ c2 ^ c3 ^ c4;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer; a start strobe at the end of a stop bit chains the next byte with no gap
module uart_byte_tx
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_done_o
);

  localparam int              BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_MAX);
  assign tx_o     = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    byte_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          byte_done_o = 1'b1;
          baud_d      = '0;
          bit_d       = '0;
          // Loading here keeps bytes back-to-back: the next start bit begins on this edge.
          if (start_i) begin
            state_d = START;
            shreg_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/vote_report_tx.sv
// rtl/vote_report_tx.sv - snapshots four tallies on request and sends A5,c1..c4,xor as a UART frame
module vote_report_tx
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       send_req,
  input  logic [7:0] cand1_votes,
  input  logic [7:0] cand2_votes,
  input  logic [7:0] cand3_votes,
  input  logic [7:0] cand4_votes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  logic [7:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;
  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_done;
  logic [2:0] next_idx;
  logic [7:0] checksum;

  assign accept   = send_req & mode & ~busy_q;
  assign next_idx = byte_idx_q + 3'd1;
  assign checksum = frame_checksum(c1_q, c2_q, c3_q, c4_q);
  assign busy     = busy_q;
  assign done     = done_q;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock      (clock),
    .reset      (reset),
    .start_i    (byte_start),
    .data_i     (byte_data),
    .tx_o       (tx),
    .byte_done_o(byte_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      c1_q       <= '0;
      c2_q       <= '0;
      c3_q       <= '0;
      c4_q       <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      c3_q       <= c3_d;
      c4_q       <= c4_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    c1_d       = c1_q;
    c2_d       = c2_q;
    c3_d       = c3_q;
    c4_d       = c4_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_start = 1'b0;
    byte_data  = SYNC_BYTE;
    if (accept) begin
      c1_d       = cand1_votes;
      c2_d       = cand2_votes;
      c3_d       = cand3_votes;
      c4_d       = cand4_votes;
      byte_idx_d = '0;
      busy_d     = 1'b1;
      byte_start = 1'b1;
    end else if (busy_q && byte_done) begin
      if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
        byte_idx_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        byte_idx_d = next_idx;
        byte_start = 1'b1;
        case (next_idx)
          3'd1:    byte_data = c1_q;
          3'd2:    byte_data = c2_q;
          3'd3:    byte_data = c3_q;
          3'd4:    byte_data = c4_q;
          default: byte_data = checksum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vote_report_tx.sv
// tb/tb_vote_report_tx.sv - directed self-checking bench for vote_report_tx at CLKS_PER_BIT = 4
module tb_vote_report_tx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] cand1_votes = 8'h00;
  logic [7:0] cand2_votes = 8'h00;
  logic [7:0] cand3_votes = 8'h00;
  logic [7:0] cand4_votes = 8'h00;
  logic       tx;
  logic       busy;
  logic       done;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  vote_report_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .send_req   (send_req),
    .cand1_votes(cand1_votes),
    .cand2_votes(cand2_votes),
    .cand3_votes(cand3_votes),
    .cand4_votes(cand4_votes),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_counts(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    cand1_votes = a;
    cand2_votes = b;
    cand3_votes = c;
    cand4_votes = d;
  endtask

  // Watches n idle cycles; every sample must show tx=1, busy=0, done=0.
  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  // Entered one step after the accept edge E0; leaves one step after E0+60*CPB.
  task automatic run_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                           input logic [7:0] e5, input bit mid);
    logic [59:0] bits;
    logic [7:0]  exp_b [6];
    int          busy_cnt, done_cnt, glitch;
    exp_b    = '{e0, e1, e2, e3, e4, e5};
    bits     = '0;
    busy_cnt = 0;
    done_cnt = 0;
    glitch   = 0;
    for (int c = 0; c < 60 * CPB; c++) begin
      if (c % CPB == 0) bits[c / CPB] = tx;
      else if (tx !== bits[c / CPB]) glitch++;
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) done_cnt++;
      if (mid) begin
        if (c == 50) begin
          cand1_votes = 8'h09;
          send_req    = 1'b1;
        end
        if (c == 52) send_req = 1'b0;
        if (c == 100) mode = 1'b0;
      end
      tick();
    end
    check({tag, " busy_cycles"}, busy_cnt, 60 * CPB);
    check({tag, " early_done"}, done_cnt, 0);
    check({tag, " bit_stable"}, glitch, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s framing%0d", tag, i), {30'd0, bits[10*i+9], bits[10*i]}, 32'd2);
      check($sformatf("%s byte%0d", tag, i), {24'd0, bits[10*i+1 +: 8]}, {24'd0, exp_b[i]});
    end
    check({tag, " done_end"}, done, 1'b1);
    check({tag, " busy_end"}, busy, 1'b0);
    check({tag, " tx_end"}, tx, 1'b1);
  endtask

  initial begin
    int done_seen;

    // Reset with nonzero counts.
    set_counts(8'h11, 8'h22, 8'h33, 8'h44);
    reset = 1'b1;
    tick();
    tick();
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0;
    idle_check("idle_after_reset", 10);

    // Single frame, counts 3/5/0/7.
    mode = 1'b1;
    set_counts(8'h03, 8'h05, 8'h00, 8'h07);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    check("f1 accept busy", busy, 1'b1);
    check("f1 accept tx", tx, 1'b0);
    run_frame("f1", 8'hA5, 8'h03, 8'h05, 8'h00, 8'h07, 8'h01, 1'b0);
    tick();
    check("f1 done_one_cycle", done, 1'b0);
    idle_check("f1 idle_after", 10);

    // Request with mode 0 is ignored.
    mode = 1'b0;
    send_req = 1'b1;
    idle_check("mode0_ignored", 20);
    send_req = 1'b0;

    // Mid-frame count change, re-request and mode drop.
    mode = 1'b1;
    set_counts(8'h03, 8'h05, 8'h00, 8'h07);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    run_frame("mid", 8'hA5, 8'h03, 8'h05, 8'h00, 8'h07, 8'h01, 1'b1);
    tick();
    idle_check("mid no_second_frame", 40);

    // Reset during byte 2 aborts without done.
    mode = 1'b1;
    set_counts(8'h03, 8'h05, 8'h00, 8'h07);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    repeat (22 * CPB) tick();
    check("abort pre busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("abort tx", tx, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 60 * CPB; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) done_seen++;
      tick();
    end
    check("abort quiet", done_seen, 0);

    set_counts(8'h12, 8'h34, 8'h56, 8'h78);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    run_frame("post_reset", 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 1'b0);
    tick();

    // All-FF counts with request held: checksum 00, next frame one cycle after done.
    set_counts(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    send_req = 1'b1;
    tick();
    run_frame("ff1", 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    tick();
    check("ff2 restart busy", busy, 1'b1);
    check("ff2 restart tx", tx, 1'b0);
    check("ff2 restart done_low", done, 1'b0);
    send_req = 1'b0;
    run_frame("ff2", 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    tick();
    idle_check("ff final_idle", 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vote_report_tx.md
# vote_report_tx

Serial result reporter for the voting machine. In result mode, a request snapshots the four 8-bit candidate tallies and sends them as a framed UART byte stream with a checksum. It sits beside the mode/LED controller, reads the vote logger's count outputs, and drives one external `tx` pin. It is the read-out end of the tally path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (868 gives 115200 baud at 100 MHz). Minimum 2.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 1: 0 = voting mode, 1 = result mode. Requests are accepted only when `mode` = 1.
- `send_req` in 1: request to send a report; level sampled every cycle.
- `cand1_votes` … `cand4_votes` in 8 each: live tallies from the vote logger.
- `tx` out 1: serial output; idle high.
- `busy` out 1: high while a frame is in flight.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- Accept condition: `send_req` & `mode` & !`busy` at a rising edge.
- On accept, snapshot the four counts into internal registers. Later changes to the count inputs do not affect the frame in flight.
- Frame is 6 bytes, in order: 0xA5 (sync), c1, c2, c3, c4, then checksum = c1^c2^c3^c4.
- Each byte is 10 bits:
  - start bit 0;
  - data bits 0..7, LSB first;
  - stop bit 1.
- Every bit lasts exactly `CLKS_PER_BIT` cycles.
- Bytes go back-to-back with no idle gap.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if bytes remain; STOP → IDLE after byte index 5.
- Counters:
  - baud counter 0..`CLKS_PER_BIT`-1;
  - bit index 0..7;
  - byte index 0..5.
- Requests while `busy` are ignored, not queued.
- A request with `mode` = 0 is ignored.
- `mode` falling to 0 mid-frame does not abort; the frame completes.
- Reset mid-frame aborts immediately; no `done` is produced.
- Counts are 8-bit unsigned and sent as-is. Tally wrap-around (0xFF+1 = 0x00) is the logger's concern, not this block's.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `done` = 0, FSM = IDLE, all counters 0.
- All outputs are registered.
- Accept at edge E0: from E0, `busy` = 1 and `tx` = 0 (start bit of byte 0).
- Bit k of the frame (k = 0..59) is driven from edge E0 + k·`CLKS_PER_BIT`.
- At edge E0 + 60·`CLKS_PER_BIT`:
  - `busy` = 0, `tx` = 1;
  - `done` = 1 for exactly one cycle.
- Earliest next accept is the edge after `done` rises. A request held high continuously therefore yields frames separated by one idle cycle of `tx` = 1.
- Reset at any edge: the outputs take their reset values from that edge.

## Structure
- Shared package `vote_pkg` holds:
  - `SYNC_BYTE` = 8'hA5;
  - `FRAME_BYTES` = 6;
  - the FSM state enum (IDLE, START, DATA, STOP).
- Natural sub-module: `uart_byte_tx`, which serializes one byte with its own baud and bit counters and returns a byte-done strobe.
- Top level holds:
  - the snapshot registers;
  - the checksum;
  - the byte-index sequencer;
  - `busy`/`done` generation.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4, so one frame is 240 cycles.
- Reset with the counts nonzero → `tx` = 1, `busy` = 0, `done` = 0; stays idle with no request.
- `mode` = 1, counts 3/5/0/7, one-cycle `send_req` → decoded bytes A5, 03, 05, 00, 07, 01; `busy` for 240 cycles; single `done` pulse at E0+240.
- `send_req` held with `mode` = 0 for 20 cycles → `tx` stays 1, `busy` stays 0, no `done`.
- Mid-frame: c1 changes 3→9, `send_req` re-pulsed, and `mode` drops to 0 → frame still carries 03 and checksum 01; no second frame; `done` pulses once.
- Reset asserted during byte 2 → `tx` = 1 and `busy` = 0 from that edge; no `done`. A new request after reset sends a complete, correct frame.
- Counts FF/FF/FF/FF with `send_req` held high → checksum byte 00. The second frame's start bit begins exactly one cycle after the first `done`.
